wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NSRC, default 3, meaning the number of writeback sources: index 0 = mem, 1 = fpu, 2 = alu.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the queue entries per source.
REQ-003 SHALL have parameter AGE_MAX, default 4, meaning the wait cycles after which a source is aged.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port src_valid, input, NSRC bits: per-source write request.
REQ-007 SHALL have port src_ready, output, NSRC bits: per-source queue can accept.
REQ-008 SHALL have port src_addr, input, NSRC*LEN_REG_ADDR bits: per-source destination register.
REQ-009 SHALL have port src_data, input, NSRC*LEN_WORD bits: per-source write data.
REQ-010 SHALL have port ard, output, LEN_REG_ADDR bits: register-file write address; 0 means no write.
REQ-011 SHALL have port drd, output, LEN_WORD bits: register-file write data.
REQ-012 SHALL have port qaddr, input, LEN_REG_ADDR bits: hazard query address.
REQ-013 SHALL have port qhit, output, 1 bit: a queued or in-flight write targets qaddr.
REQ-014 SHALL have port busy, output, 1 bit: any queue non-empty, or ard nonzero.

Function
REQ-015 SHALL accept a request on source i at a rising edge when src_valid[i] and src_ready[i] are both high.
REQ-016 SHALL drive src_ready[i] high iff the queue of source i holds fewer than DEPTH entries; src_ready SHALL come from state only, with no combinational path from valid or grant.
REQ-017 SHALL discard accepted requests with src_addr equal to 0 without enqueuing them.
REQ-018 SHALL let an accepted entry become a grant candidate in the cycle after acceptance.
REQ-019 SHALL grant at most one non-empty queue head per cycle and pop it at that edge.
REQ-020 SHALL register ard/drd from the granted head at that same edge, so an uncontested write reaches ard two cycles after its src_valid cycle.
REQ-021 SHALL drive ard to 0 in any cycle following a cycle with no grant; each granted write SHALL appear on ard/drd for exactly one cycle.
REQ-022 SHALL use fixed priority mem > fpu > alu among non-aged candidates.
REQ-023 SHALL keep a per-source wait counter that increments, saturating at AGE_MAX, each cycle the queue is non-empty and not granted, and clears on grant or when the queue is empty.
REQ-024 SHALL treat a source whose counter equals AGE_MAX as aged; aged candidates SHALL beat non-aged ones, with fixed priority among aged candidates.
REQ-025 SHALL preserve FIFO order within one source and SHALL NOT order writes across sources; cross-source ordering is the issue logic's duty, using qhit.
REQ-026 SHALL leave the queue count unchanged on a simultaneous push and pop on the same source; the pushed entry lands behind the remaining entries.
REQ-027 SHALL compute qhit combinationally: high iff qaddr is nonzero and matches a valid entry of any queue, or the current ard.
REQ-028 SHALL exclude same-cycle incoming src_addr values from qhit.

Reset
REQ-029 SHALL, while rstn is low at a rising edge, empty all queues, clear all wait counters, and set ard=0 and drd=0.
REQ-030 SHALL drive src_ready to all ones, busy=0 and qhit=0 in the cycle after reset.
REQ-031 SHALL drop, not commit, requests presented during reset; a reset mid-operation SHALL discard all queued writes.

Structure
REQ-032 SHALL take LEN_REG_ADDR and LEN_WORD from the shared include.vh.
REQ-033 SHALL add WB_NSRC, WB_DEPTH, WB_AGE_MAX and the source index constants (WB_SRC_MEM/FPU/ALU) to include.vh.
REQ-034 SHALL implement each queue as one sub-module wb_fifo (parameters DEPTH, width LEN_REG_ADDR+LEN_WORD), with ports push, pop, din, dout, empty, full and per-entry address taps for qhit, instantiated NSRC times.

Verification
REQ-035 SHALL verify single write: alu valid for 1 cycle with addr=5, data=0xDEADBEEF at cycle 10 -> ard=5, drd=0xDEADBEEF in cycle 12 only, then ard=0.
REQ-036 SHALL verify priority: mem(addr 3), fpu(addr 4) and alu(addr 6) all valid in the same cycle -> ard sequence 3, 4, 6 on three consecutive cycles.
REQ-037 SHALL verify aging: mem kept non-empty continuously with alu holding 1 entry -> alu granted no later than its 5th waiting cycle, with mem resuming afterwards.
REQ-038 SHALL verify backpressure: fpu pushes 3 writes back-to-back while mem saturates the port -> src_ready[1]=0 after 2 accepts, the 3rd is held, and fpu order is preserved on ard.
REQ-039 SHALL verify address 0 and qhit: alu writes addr=0 -> never appears on ard and busy stays 0; a queued write to addr 7 with qaddr=7 -> qhit=1 until the cycle after it leaves ard.
REQ-040 SHALL verify reset mid-operation: rstn low for 1 cycle with 2 writes queued -> neither write appears on ard, and src_ready=all ones in the next cycle.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - widths and defaults for the writeback arbiter
package wb_arbiter_pkg;
`include "include.vh"

  localparam int LEN_REG_ADDR = `LEN_REG_ADDR;
  localparam int LEN_WORD     = `LEN_WORD;
  localparam int WB_NSRC      = `WB_NSRC;
  localparam int WB_DEPTH     = `WB_DEPTH;
  localparam int WB_AGE_MAX   = `WB_AGE_MAX;
  localparam int WB_SRC_MEM   = `WB_SRC_MEM;
  localparam int WB_SRC_FPU   = `WB_SRC_FPU;
  localparam int WB_SRC_ALU   = `WB_SRC_ALU;

endpackage

// File: rtl/include.vh
// rtl/include.vh - shared widths and writeback-arbiter constants
`ifndef INCLUDE_VH
`define INCLUDE_VH

`define LEN_REG_ADDR 5
`define LEN_WORD     32

`define WB_NSRC      3
`define WB_DEPTH     2
`define WB_AGE_MAX   4
`define WB_SRC_MEM   0
`define WB_SRC_FPU   1
`define WB_SRC_ALU   2

`endif

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source writeback queue, head at entry 0, with address taps
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  parameter int TAPW  = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [DEPTH*TAPW-1:0]   tap_addr,
  output logic [DEPTH-1:0]        tap_valid
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  // with a same-cycle pop the new entry lands one slot lower, behind the survivors
  assign wr_idx  = do_pop ? count - CW'(1) : count;
  assign dout    = mem[0];

  always_comb begin
    mem_nxt = mem;
    if (do_pop) begin
      for (int k = 0; k < DEPTH - 1; k++) mem_nxt[k] = mem[k+1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (do_push && CW'(k) == wr_idx) mem_nxt[k] = din;
    end
  end

  always_comb begin
    tap_addr  = '0;
    tap_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      tap_addr[k*TAPW +: TAPW] = mem[k][WIDTH-1 -: TAPW];
      tap_valid[k]             = CW'(k) < count;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) count <= '0;
    else       count <= count + CW'(do_push) - CW'(do_pop);
    mem <= mem_nxt;
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter: per-source queues, fixed priority with aging
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NSRC    = WB_NSRC,
  parameter int DEPTH   = WB_DEPTH,
  parameter int AGE_MAX = WB_AGE_MAX
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NSRC-1:0]              src_valid,
  output logic [NSRC-1:0]              src_ready,
  input  logic [NSRC*LEN_REG_ADDR-1:0] src_addr,
  input  logic [NSRC*LEN_WORD-1:0]     src_data,
  output logic [LEN_REG_ADDR-1:0]      ard,
  output logic [LEN_WORD-1:0]          drd,
  input  logic [LEN_REG_ADDR-1:0]      qaddr,
  output logic                         qhit,
  output logic                         busy
);
  localparam int EW  = LEN_REG_ADDR + LEN_WORD;
  localparam int AGW = $clog2(AGE_MAX + 1);

  logic [NSRC-1:0]                 empty;
  logic [NSRC-1:0]                 full;
  logic [NSRC-1:0]                 push;
  logic [NSRC-1:0]                 grant;
  logic [NSRC-1:0]                 aged;
  logic [NSRC-1:0]                 cand;
  logic [EW-1:0]                   head     [NSRC];
  logic [DEPTH*LEN_REG_ADDR-1:0]   taps     [NSRC];
  logic [DEPTH-1:0]                tap_v    [NSRC];
  logic [AGW-1:0]                  wait_cnt [NSRC];
  logic [EW-1:0]                   gnt_entry;
  logic                            found;
  logic                            hit;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [LEN_REG_ADDR-1:0] addr_i;
    assign addr_i       = src_addr[i*LEN_REG_ADDR +: LEN_REG_ADDR];
    // writes to register 0 are accepted but never enqueued
    assign push[i]      = src_valid[i] && src_ready[i] && (addr_i != '0);
    assign src_ready[i] = !full[i];

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(EW), .TAPW(LEN_REG_ADDR)) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push[i]),
      .pop       (grant[i]),
      .din       ({addr_i, src_data[i*LEN_WORD +: LEN_WORD]}),
      .dout      (head[i]),
      .empty     (empty[i]),
      .full      (full[i]),
      .tap_addr  (taps[i]),
      .tap_valid (tap_v[i])
    );

    always_ff @(posedge clk) begin
      if (!rstn || empty[i] || grant[i]) wait_cnt[i] <= '0;
      else if (wait_cnt[i] != AGW'(AGE_MAX)) wait_cnt[i] <= wait_cnt[i] + AGW'(1);
    end
  end

  always_comb begin
    aged      = '0;
    grant     = '0;
    found     = 1'b0;
    gnt_entry = '0;
    for (int i = 0; i < NSRC; i++) aged[i] = !empty[i] && (wait_cnt[i] == AGW'(AGE_MAX));
    cand = (|aged) ? aged : ~empty;
    for (int i = 0; i < NSRC; i++) begin
      if (cand[i] && !found) begin
        grant[i]  = 1'b1;
        found     = 1'b1;
        gnt_entry = head[i];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (tap_v[i][k] && taps[i][k*LEN_REG_ADDR +: LEN_REG_ADDR] == qaddr) hit = 1'b1;
      end
    end
    qhit = (qaddr != '0) && (hit || ard == qaddr);
  end

  assign busy = !(&empty) || (ard != '0);

  always_ff @(posedge clk) begin
    if (!rstn || !found) begin
      ard <= '0;
      drd <= '0;
    end else begin
      {ard, drd} <= gnt_entry;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed table, corner sequences and random run against a queue model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int AW  = LEN_REG_ADDR;
  localparam int DW  = LEN_WORD;
  localparam int AGE = WB_AGE_MAX;

  logic            clk = 1'b0;
  logic            rstn;
  logic [2:0]      src_valid;
  logic [2:0]      src_ready;
  logic [3*AW-1:0] src_addr;
  logic [3*DW-1:0] src_data;
  logic [AW-1:0]   ard;
  logic [DW-1:0]   drd;
  logic [AW-1:0]   qaddr;
  logic            qhit;
  logic            busy;

  int n_vec = 0;
  int n_bad = 0;

  wb_arbiter dut (
    .clk(clk), .rstn(rstn), .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data), .ard(ard), .drd(drd),
    .qaddr(qaddr), .qhit(qhit), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq [3][$];
  int            mw [3];
  logic [AW-1:0] m_ard;
  logic [DW-1:0] m_drd;

  typedef struct {
    logic          r;
    logic [2:0]    v;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] d;
    logic [AW-1:0] qa;
    logic [AW-1:0] e_ard;
    logic [DW-1:0] e_drd;
    logic [2:0]    e_rdy;
    logic          e_busy;
    logic          e_qhit;
  } vec_t;

  vec_t tbl[$];
  vec_t none;

  function automatic vec_t mk(bit r, bit [2:0] v, bit [AW-1:0] a0, a1, a2, bit [DW-1:0] d,
                              bit [AW-1:0] qa, bit [AW-1:0] ea, bit [DW-1:0] ed,
                              bit [2:0] er, bit eb, bit eq);
    vec_t x;
    x.r = r; x.v = v; x.a0 = a0; x.a1 = a1; x.a2 = a2; x.d = d; x.qa = qa;
    x.e_ard = ea; x.e_drd = ed; x.e_rdy = er; x.e_busy = eb; x.e_qhit = eq;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] m_rdy();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = mq[i].size() < WB_DEPTH;
    return r;
  endfunction

  function automatic logic m_busy();
    int n = 0;
    for (int i = 0; i < 3; i++) n += mq[i].size();
    return (n > 0) || (m_ard != 0);
  endfunction

  function automatic logic m_qhit(input logic [AW-1:0] qa);
    if (qa == 0) return 1'b0;
    if (m_ard == qa) return 1'b1;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < mq[i].size(); k++)
        if (mq[i][k].a == qa) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int         g;
    logic [2:0] rdy;
    ent_t       e;
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin mq[i].delete(); mw[i] = 0; end
      m_ard = 0; m_drd = 0;
      return;
    end
    rdy = m_rdy();
    g = -1;
    for (int i = 0; i < 3; i++) if (g < 0 && mq[i].size() > 0 && mw[i] == AGE) g = i;
    for (int i = 0; i < 3; i++) if (g < 0 && mq[i].size() > 0) g = i;
    for (int i = 0; i < 3; i++)
      mw[i] = (mq[i].size() == 0 || i == g) ? 0 : (mw[i] < AGE ? mw[i] + 1 : AGE);
    if (g >= 0) begin
      e = mq[g].pop_front();
      m_ard = e.a; m_drd = e.d;
    end else begin
      m_ard = 0; m_drd = 0;
    end
    for (int i = 0; i < 3; i++) begin
      e.a = src_addr[i*AW +: AW];
      e.d = src_data[i*DW +: DW];
      if (src_valid[i] && rdy[i] && e.a != 0) mq[i].push_back(e);
    end
  endtask

  task automatic tick(input bit cmp, input bit use_tbl, input vec_t e);
    @(negedge clk);
    if (cmp) begin
      chk("model_ard", ard, m_ard);
      if (m_ard != 0) chk("model_drd", drd, m_drd);
      chk("model_ready", src_ready, m_rdy());
      chk("model_busy", busy, m_busy());
      chk("model_qhit", qhit, m_qhit(qaddr));
    end
    if (use_tbl) begin
      chk("tbl_ard", ard, e.e_ard);
      if (e.e_ard != 0) chk("tbl_drd", drd, e.e_drd);
      chk("tbl_ready", src_ready, e.e_rdy);
      chk("tbl_busy", busy, e.e_busy);
      chk("tbl_qhit", qhit, e.e_qhit);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    src_valid = '0; src_addr = '0; src_data = '0; qaddr = '0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    tick(1'b0, 1'b0, none);
    rstn = 1'b1;
  endtask

  logic [AW-1:0] exp_age [7];
  logic [AW-1:0] got[$];
  int            fidx;
  int            held;
  logic          rdy_pre;

  initial begin
    none = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //          r  v       a0 a1 a2 data          qa  ard drd           rdy busy qhit
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            0, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b100, 0, 0, 5, 32'hDEADBEEF, 5, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            5, 0, 0,            7, 1, 1));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            5, 5, 32'hDEADBEEF, 7, 1, 1));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            5, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b111, 3, 4, 6, 32'h11111111, 0, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            0, 0, 0,            7, 1, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            0, 3, 32'h11111111, 7, 1, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            0, 4, 32'h11111111, 7, 1, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            0, 6, 32'h11111111, 7, 1, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            0, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b100, 0, 0, 0, 32'h5,        0, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            0, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            0, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b100, 0, 0, 7, 32'h77,       7, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            7, 0, 0,            7, 1, 1));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            7, 7, 32'h77,       7, 1, 1));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            7, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b011, 8, 9, 0, 32'h22,       0, 0, 0,            7, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0,            9, 0, 0,            7, 1, 1));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            9, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            8, 0, 0,            7, 0, 0));
    tbl.push_back(mk(0, 3'b111, 1, 2, 3, 32'h33,       0, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            2, 0, 0,            7, 0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0,            2, 0, 0,            7, 0, 0));

    do_reset();
    foreach (tbl[n]) begin
      rstn      = tbl[n].r;
      src_valid = tbl[n].v;
      src_addr  = {tbl[n].a2, tbl[n].a1, tbl[n].a0};
      src_data  = {3{tbl[n].d}};
      qaddr     = tbl[n].qa;
      tick(1'b1, 1'b1, tbl[n]);
    end

    // aging: mem stays busy, a single alu write must win once aged
    exp_age = '{0, 10, 10, 10, 10, 20, 10};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      src_valid = {c == 0, 1'b0, 1'b1};
      src_addr  = {5'd20, 5'd0, 5'd10};
      src_data  = {32'hA1, 32'h0, 32'(c)};
      tick(1'b1, 1'b0, none);
      chk($sformatf("age_ard_c%0d", c + 1), ard, exp_age[c]);
    end

    // backpressure: fpu burst of three against a saturating mem source
    do_reset();
    got.delete();
    fidx = 0;
    held = 0;
    for (int c = 0; c < 46; c++) begin
      src_valid = {1'b0, c < 40 && fidx < 3, c < 40};
      src_addr  = {5'd0, 5'(11 + fidx), 5'd10};
      src_data  = {32'h0, 32'(fidx), 32'hC0};
      rdy_pre   = src_ready[1];
      if (c == 2) chk("bp_fpu_ready_after_2", rdy_pre, 1'b0);
      if (src_valid[1] && !rdy_pre) held++;
      tick(1'b1, 1'b0, none);
      if (src_valid[1] && rdy_pre) fidx++;
      if (ard >= 11 && ard <= 13) got.push_back(ard);
    end
    chk("bp_third_held", held > 0, 1'b1);
    chk("bp_count", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++) chk($sformatf("bp_order%0d", k), got[k], 11 + k);

    // randomized traffic against the model, with occasional resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rstn      = ($urandom_range(0, 63) != 0);
      src_valid = 3'($urandom);
      src_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      src_data  = {$urandom, $urandom, $urandom};
      qaddr     = 5'($urandom_range(0, 7));
      tick(1'b1, 1'b0, none);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
